// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - Shared encodings and helpers for the program-counter stage
//
// Purpose: PC-select codes driven by the control unit, PC-stage state
// encodings, and the fetch-range test used by pc_unit.
// Ports: none (package).
package pc_unit_pkg;

  // PCSel codes from the control unit
  localparam logic [1:0] PCSEL_NEXT = 2'b00;  // NextIns
  localparam logic [1:0] PCSEL_REL  = 2'b01;  // RelJmp
  localparam logic [1:0] PCSEL_ABS  = 2'b10;  // AbsJmp
  localparam logic [1:0] PCSEL_HALT = 2'b11;  // HALT

  typedef enum logic [1:0] {
    PC_RUN    = 2'b00,
    PC_HALTED = 2'b01,
    PC_FAULT  = 2'b10
  } pc_state_e;

  // True when a fetch at addr would fall outside instruction memory.
  // Compared at 33 bits so a limit of 2^32 bytes can never be reached.
  function automatic logic fetch_out_of_range(input logic [31:0] addr,
                                              input logic [32:0] limit);
    return {1'b0, addr} >= limit;
  endfunction

endpackage

// File: rtl/pc_unit_next_pc.sv
// rtl/pc_unit_next_pc.sv - Combinational next-PC and PC+4 calculation
//
// Purpose: derives PC+4 and the candidate next PC from the PC-select code.
// Ports:
//   PC     in  32  current fetch address
//   PCSel  in   2  next-PC select (NextIns / RelJmp / AbsJmp / HALT)
//   Immd   in  32  sign-extended branch word offset
//   JAddr  in  26  absolute jump word index (instruction[25:0])
//   PC4    out 32  PC + 4 (mod 2^32)
//   NextPC out 32  selected next PC; equals PC4 for HALT (unused there)
module next_pc_calc
  import pc_unit_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [1:0]  PCSel,
  input  logic [31:0] Immd,
  input  logic [25:0] JAddr,
  output logic [31:0] PC4,
  output logic [31:0] NextPC
);

  logic [31:0] rel_target;
  logic [31:0] abs_target;

  assign PC4        = PC + 32'd4;
  // Immd is a word offset; the shift drops its top two bits by design.
  assign rel_target = PC4 + {Immd[29:0], 2'b00};
  // Absolute jumps stay inside the 256 MiB region of the following instruction.
  assign abs_target = {PC4[31:28], JAddr, 2'b00};

  always_comb begin
    NextPC = PC4;
    case (PCSel)
      PCSEL_REL: NextPC = rel_target;
      PCSEL_ABS: NextPC = abs_target;
      default:   NextPC = PC4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Program-counter stage with halt, resume, stall and fetch fault
//
// Purpose: holds the architectural PC, advances it per PCSel, counts committed
// instructions and tracks RUN / HALTED / FAULT.
// Ports:
//   CLK       in   1  clock, rising edge
//   nRST      in   1  asynchronous active-low reset
//   PCSel     in   2  next-PC select
//   Immd      in  32  branch word offset
//   JAddr     in  26  absolute jump target word index
//   Stall     in   1  freeze all state this cycle
//   Resume    in   1  restart pulse while HALTED
//   PC        out 32  current fetch address
//   PC4       out 32  PC + 4 (combinational)
//   Halted    out  1  state is HALTED
//   Fault     out  1  state is FAULT
//   InstCount out 32  committed instruction count
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  PCSel,
  input  logic [31:0] Immd,
  input  logic [25:0] JAddr,
  input  logic        Stall,
  input  logic        Resume,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] InstCount
);

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("pc_unit: RESET_PC must be word-aligned");
  end

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] next_pc;

  next_pc_calc u_next_pc (
    .PC     (pc_q),
    .PCSel  (PCSel),
    .Immd   (Immd),
    .JAddr  (JAddr),
    .PC4    (PC4),
    .NextPC (next_pc)
  );

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= PC_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      PC_RUN: begin
        if (!Stall) begin
          // Every unstalled RUN cycle commits, including HALT and a faulting fetch.
          cnt_d = cnt_q + 32'd1;
          if (PCSel == PCSEL_HALT) begin
            state_d = PC_HALTED;
          end else if (fetch_out_of_range(next_pc, IMEM_LIMIT)) begin
            state_d = PC_FAULT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      PC_HALTED: begin
        // Stall outranks Resume; PCSel is irrelevant here.
        if (!Stall && Resume) begin
          if (fetch_out_of_range(PC4, IMEM_LIMIT)) begin
            state_d = PC_FAULT;
          end else begin
            pc_d    = PC4;
            state_d = PC_RUN;
          end
        end
      end
      PC_FAULT: begin
        state_d = PC_FAULT;
      end
      default: begin
        // Unused encoding: park safely until reset.
        state_d = PC_FAULT;
      end
    endcase
  end

  // Outputs
  always_comb begin
    Halted    = (state_q == PC_HALTED);
    Fault     = (state_q == PC_FAULT);
    PC        = pc_q;
    InstCount = cnt_q;
  end

endmodule
